addsub_arbiter: RTL

- Shares one pipelined floating-point add/sub unit between two requesters (Req0, Req1).
- Performs round-robin arbitration with a valid/ready handshake on each requester port.
- Steers the winning operands and opcode onto the unit inputs through 2:1 selection.
- Tracks in-flight operations by requester ID so each result is returned to the requester that issued it, with a pulsed response valid.

---
 rtl/addsub_arbiter_pkg.sv | 17 +
 rtl/addsub_tag_pipe.sv | 64 ++++++
 rtl/addsub_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/addsub_arbiter_pkg.sv
// Shared constants and types for the two-requester add/sub arbiter.
package addsub_arbiter_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int DEFAULT_LATENCY = 3;

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

endpackage

// File: rtl/addsub_tag_pipe.sv
// Tracks in-flight operations by requester ID alongside the shared unit's
// pipeline and counts how many results are still outstanding.
module addsub_tag_pipe
  import addsub_arbiter_pkg::*;
#(
  parameter int Latency = DEFAULT_LATENCY,
  parameter int CntW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue,
  input  logic            issue_id,
  output logic            resp0_valid,
  output logic            resp1_valid,
  output logic [CntW-1:0] in_flight
);

  tag_t            tag_q [Latency];
  tag_t            tag_d [Latency];
  logic [CntW-1:0] in_flight_q;
  logic [CntW-1:0] in_flight_d;
  logic            resp_vld_s;
  logic            resp_id_s;

  always_comb begin
    tag_d[0].vld = issue;
    tag_d[0].id  = issue_id;
    for (int i = 1; i < Latency; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  assign resp_vld_s = tag_q[Latency-1].vld;
  assign resp_id_s  = tag_q[Latency-1].id;

  // An issue and a response in the same cycle cancel out.
  always_comb begin
    in_flight_d = in_flight_q;
    case ({issue, resp_vld_s})
      2'b10:   in_flight_d = in_flight_q + CntW'(1);
      2'b01:   in_flight_d = in_flight_q - CntW'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Latency; i++) begin
        tag_q[i] <= '0;
      end
      in_flight_q <= '0;
    end else begin
      for (int i = 0; i < Latency; i++) begin
        tag_q[i] <= tag_d[i];
      end
      in_flight_q <= in_flight_d;
    end
  end

  assign resp0_valid = resp_vld_s & (resp_id_s == REQ0);
  assign resp1_valid = resp_vld_s & (resp_id_s == REQ1);
  assign in_flight   = in_flight_q;

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin sharing of one pipelined add/sub unit between two requesters,
// with results routed back to the issuing requester.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int DataSize = 32,
  parameter int Latency  = DEFAULT_LATENCY,
  parameter int CntW     = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Req0Valid,
  input  logic [DataSize-1:0] Req0A,
  input  logic [DataSize-1:0] Req0B,
  input  logic                Req0Op,
  output logic                Req0Ready,
  input  logic                Req1Valid,
  input  logic [DataSize-1:0] Req1A,
  input  logic [DataSize-1:0] Req1B,
  input  logic                Req1Op,
  output logic                Req1Ready,
  output logic                UnitValid,
  output logic [DataSize-1:0] UnitA,
  output logic [DataSize-1:0] UnitB,
  output logic                UnitOp,
  output logic                Sel,
  input  logic [DataSize-1:0] UnitResult,
  output logic                Resp0Valid,
  output logic                Resp1Valid,
  output logic [DataSize-1:0] RespData,
  output logic [CntW-1:0]     InFlight
);

  logic prio_q;
  logic prio_d;
  logic sel_q;
  logic sel_d;
  logic grant_s;
  logic issue_s;

  // With no requester valid the grant falls back to the last winner so Sel
  // does not toggle on idle cycles.
  always_comb begin
    issue_s = (Req0Valid | Req1Valid) & ~Reset;
    grant_s = sel_q;
    if (Req0Valid && Req1Valid) begin
      grant_s = prio_q;
    end else if (Req0Valid) begin
      grant_s = REQ0;
    end else if (Req1Valid) begin
      grant_s = REQ1;
    end else begin
      grant_s = sel_q;
    end

    prio_d = prio_q;
    sel_d  = sel_q;
    if (issue_s) begin
      prio_d = ~grant_s;
      sel_d  = grant_s;
    end else begin
      prio_d = prio_q;
      sel_d  = sel_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prio_q <= REQ0;
      sel_q  <= REQ0;
    end else begin
      prio_q <= prio_d;
      sel_q  <= sel_d;
    end
  end

  assign Sel       = grant_s;
  assign UnitValid = issue_s;
  assign Req0Ready = issue_s & (grant_s == REQ0);
  assign Req1Ready = issue_s & (grant_s == REQ1);
  assign UnitA     = (grant_s == REQ1) ? Req1A  : Req0A;
  assign UnitB     = (grant_s == REQ1) ? Req1B  : Req0B;
  assign UnitOp    = (grant_s == REQ1) ? Req1Op : Req0Op;
  assign RespData  = UnitResult;

  addsub_tag_pipe #(
    .Latency (Latency),
    .CntW    (CntW)
  ) u_tag_pipe (
    .clk         (Clk),
    .rst         (Reset),
    .issue       (issue_s),
    .issue_id    (grant_s),
    .resp0_valid (Resp0Valid),
    .resp1_valid (Resp1Valid),
    .in_flight   (InFlight)
  );

endmodule
